// File: rtl/led_fade_pkg.sv
// Shared constants and parameter checks for the LED PWM fader.
// Per-channel ramp state encoding lives here too.
package led_fade_pkg;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RAMP_UP,
        CH_RAMP_DOWN
    } ch_state_e;

    function automatic int fade_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic bit prescale_ok(input int prescale);
        return prescale >= 1;
    endfunction

    function automatic bit step_ok(input int step, input int bits);
        return (step >= 1) && (step <= fade_max(bits));
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level, saturating ramp and PWM compare.
// Ramp direction is derived from level vs. target, not stored.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable_i,
    input  logic                period_end_i,
    input  logic                target_on_i,
    input  logic [PWM_BITS-1:0] pwm_cnt_i,
    output logic                led_o,
    output logic                active_o
);

    localparam int MAX = fade_max(PWM_BITS);
    localparam logic [PWM_BITS-1:0] LVL_MAX = PWM_BITS'(MAX);
    localparam logic [PWM_BITS:0]   MAX_W   = (PWM_BITS + 1)'(MAX);
    localparam logic [PWM_BITS:0]   STEP_W  = (PWM_BITS + 1)'(STEP);

    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] level_d;
    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS:0]   down_diff;
    logic                led_q;
    logic                led_d;
    ch_state_e           state;

    always_comb begin
        target = target_on_i ? LVL_MAX : '0;
        state  = CH_IDLE;
        if (level_q < target) begin
            state = CH_RAMP_UP;
        end else if (level_q > target) begin
            state = CH_RAMP_DOWN;
        end
    end

    // One extra bit exposes overflow (sum) and borrow (difference).
    always_comb begin
        up_sum    = {1'b0, level_q} + STEP_W;
        down_diff = {1'b0, level_q} - STEP_W;
        level_d   = level_q;
        if (period_end_i) begin
            unique case (state)
                CH_RAMP_UP: begin
                    level_d = (up_sum > MAX_W) ? LVL_MAX
                                               : up_sum[PWM_BITS-1:0];
                end
                CH_RAMP_DOWN: begin
                    level_d = down_diff[PWM_BITS] ? '0
                                                  : down_diff[PWM_BITS-1:0];
                end
                default: level_d = level_q;
            endcase
        end
        led_d = enable_i
              && ((level_q == LVL_MAX) || (pwm_cnt_i < level_q));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led_o    = led_q;
    assign active_o = (state != CH_IDLE);

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader between the LED PIO out_port and the LED pins.
// Shared prescaler/PWM counter drive NUM_LEDS independent channels.
module led_pwm_fader
    import led_fade_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 64,
    parameter int STEP     = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_LEDS-1:0] led_in,
    input  logic                enable,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                busy
);

    localparam int MAX   = fade_max(PWM_BITS);
    localparam int PRE_W = cnt_width(PRESCALE);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(MAX);

    if (!prescale_ok(PRESCALE)) begin : g_bad_prescale
        $error("led_pwm_fader: PRESCALE must be >= 1");
    end

    if (!step_ok(STEP, PWM_BITS)) begin : g_bad_step
        $error("led_pwm_fader: STEP must be in 1..2**PWM_BITS-1");
    end

    logic [NUM_LEDS-1:0] led_q;
    logic [PRE_W-1:0]    pre_cnt_q;
    logic [PRE_W-1:0]    pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_d;
    logic                busy_q;
    logic                busy_d;
    logic                tick;
    logic                period_end;
    logic [NUM_LEDS-1:0] active;
    logic [NUM_LEDS-1:0] led_bits;

    always_comb begin
        tick       = enable && (pre_cnt_q == PRE_LAST);
        period_end = tick && (pwm_cnt_q == PWM_LAST);
        pre_cnt_d  = pre_cnt_q;
        pwm_cnt_d  = pwm_cnt_q;
        if (!enable) begin
            pre_cnt_d = '0;
            pwm_cnt_d = '0;
        end else begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
            if (tick) begin
                pwm_cnt_d = pwm_cnt_q + 1'b1;
            end
        end
        busy_d = |active;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            led_q     <= '0;
            pre_cnt_q <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            led_q     <= led_in;
            pre_cnt_q <= pre_cnt_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS),
            .STEP     (STEP)
        ) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .enable_i     (enable),
            .period_end_i (period_end),
            .target_on_i  (led_q[i]),
            .pwm_cnt_i    (pwm_cnt_q),
            .led_o        (led_bits[i]),
            .active_o     (active[i])
        );
    end

    assign led_out = led_bits;
    assign busy    = busy_q;

endmodule
